// File: rtl/lut_interp_reader.sv
// Activation LUT reader: splits a fixed-point sample into index and fraction, then interpolates.
// Optional `LUT_INTERP_ROUND_EN` selects round-half-up in place of floor on the final shift.
module lut_interp_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] in_data,
    output logic [ADDR_W-1:0]        lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PW = DATA_W + FRAC_W + 2;
    localparam int SW = DATA_W + 2;

    localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (DATA_W - 1)));

    logic                     adv;
    logic                     xfer;
    logic [FRAC_W-1:0]        s1_frac;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [PW-1:0]     s2_prod;
    logic                     s2_valid;

    logic signed [DATA_W:0]   diff;
    logic signed [PW-1:0]     diff_x;
    logic signed [PW-1:0]     frac_x;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_adj;
    logic signed [PW-1:0]     shifted;
    logic signed [SW-1:0]     sum;
    logic signed [DATA_W-1:0] sat;

    // One global stall: the whole pipe freezes while a result waits downstream.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        diff   = {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
        diff_x = PW'(diff);
        frac_x = PW'({1'b0, s1_frac});
        prod   = diff_x * frac_x;
    end

    always_comb begin
`ifdef LUT_INTERP_ROUND_EN
        prod_adj = s2_prod + PW'(2 ** (FRAC_W - 1));
`else
        prod_adj = s2_prod;
`endif
        shifted = prod_adj >>> FRAC_W;
        sum     = SW'(s2_base) + SW'(shifted);
        if (sum > MAX_V) begin
            sat = DATA_W'(MAX_V);
        end else if (sum < MIN_V) begin
            sat = DATA_W'(MIN_V);
        end else begin
            sat = DATA_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_address <= '0;
            s1_frac     <= '0;
            s1_valid    <= 1'b0;
            s2_base     <= '0;
            s2_prod     <= '0;
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else if (adv) begin
            s1_valid <= xfer;
            if (xfer) begin
                lut_address <= in_data[ADDR_W+FRAC_W-1:FRAC_W];
                s1_frac     <= in_data[FRAC_W-1:0];
            end
            s2_base   <= lut_base;
            s2_prod   <= prod;
            s2_valid  <= s1_valid;
            out_data  <= sat;
            out_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_lut_interp_reader.sv
// Bench for lut_interp_reader: spec vectors, stall/reset sequences, random scoreboard.
// Expected results follow LUT_INTERP_ROUND_EN the same way the design does.
module tb_lut_interp_reader;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic [3:0]        lut_address;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;

    int checks = 0;
    int errors = 0;

    int lut [16] = '{0, 12, 15, 15, 15, 15, 15, 15,
                     -15, -15, -15, -15, -15, -15, -15, -12};

    always #5 clk = ~clk;

    // External LUT: top positive entry is flat, index 15 wraps to entry 0.
    assign lut_base = 8'(lut[lut_address]);
    assign lut_next = 8'((lut_address == 4'd7) ? lut[7] : lut[4'(lut_address + 4'd1)]);

    lut_interp_reader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    typedef struct {
        logic [7:0] din;
        int         addr;
        int         q_trunc;
        int         q_round;
    } vec_t;

    vec_t vecs [7];
    int   sb [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input logic [7:0] d);
        int idx, f, b, n, v, q;
        idx = int'(d[7:4]);
        f   = int'(d[3:0]);
        b   = lut[idx];
        n   = (idx == 7) ? b : lut[(idx + 1) % 16];
        v   = b * 16 + (n - b) * f;
`ifdef LUT_INTERP_ROUND_EN
        v = v + 8;
`endif
        q = v / 16;
        if (v < 0 && (v % 16) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic int pick(input vec_t v);
`ifdef LUT_INTERP_ROUND_EN
        return v.q_round;
`else
        return v.q_trunc;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [7:0] d, input int addr, input int exp, input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk({nm, "_addr"}, int'(lut_address), addr);
        chk({nm, "_ov_e1"}, int'(out_valid), 0);
        tick();
        chk({nm, "_ov_e2"}, int'(out_valid), 0);
        tick();
        chk({nm, "_ov_e3"}, int'(out_valid), 1);
        chk({nm, "_data"}, int'(out_data), exp);
        tick();
        chk({nm, "_ov_gone"}, int'(out_valid), 0);
    endtask

    initial begin
        logic              prev_stall;
        logic signed [7:0] prev_data;
        int                exp;

        vecs[0] = '{8'h10, 1, 12, 12};
        vecs[1] = '{8'h08, 0, 6, 6};
        vecs[2] = '{8'hF8, 15, -6, -6};
        vecs[3] = '{8'h78, 7, 15, 15};
        vecs[4] = '{8'h88, 8, -15, -15};
        vecs[5] = '{8'h13, 1, 12, 13};
        vecs[6] = '{8'hE5, 14, -15, -14};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_lut_address", int'(lut_address), 0);
        tick();
        rst = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) begin
            single(vecs[i].din, vecs[i].addr, pick(vecs[i]), $sformatf("vec%0d", i));
        end

        // Burst of three into a stalled sink.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h08;
        tick();
        in_data = 8'h10;
        tick();
        in_data = 8'hF8;
        tick();
        in_valid = 1'b0;
        chk("burst_ov", int'(out_valid), 1);
        chk("burst_in_ready_low", int'(in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_hold_ov", int'(out_valid), 1);
            chk("burst_hold_a", int'(out_data), 6);
            chk("burst_hold_addr", int'(lut_address), 15);
            chk("burst_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("burst_b_ov", int'(out_valid), 1);
        chk("burst_b", int'(out_data), 12);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("burst_hold_b", int'(out_data), 12);
        end
        out_ready = 1'b1;
        tick();
        chk("burst_c_ov", int'(out_valid), 1);
        chk("burst_c", int'(out_data), -6);
        tick();
        chk("burst_empty", int'(out_valid), 0);

        // Reset with two samples in flight.
        in_valid = 1'b1;
        in_data  = 8'h08;
        tick();
        in_data = 8'h10;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_ov", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_addr", int'(lut_address), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_flushed", int'(out_valid), 0);
        end
        single(8'h10, 1, 12, "post_rst");

        // Random traffic against the scoreboard.
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                chk("rnd_stall_ov", int'(out_valid), 1);
                chk("rnd_stall_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    chk("rnd_data", int'(out_data), exp);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                exp = sb.pop_front();
                chk("drain_data", int'(out_data), exp);
            end
            tick();
        end
        chk("drain_left", sb.size(), 0);
        tick();
        chk("drain_idle", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
